pc_hazard_ctrl: RTL and testbench

PC_HAZARD_CTRL -- requirements
Module: pc_hazard_ctrl

---
 rtl/pc_hazard_ctrl_pkg.sv | 6 +
 rtl/pc_hazard_ctrl_hazard_detect.sv | 10 +
 rtl/pc_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_pc_hazard_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pc_hazard_ctrl_pkg.sv
// pc_hazard_ctrl_pkg: shared pipeline control types and constants.
package pc_hazard_ctrl_pkg;
  typedef enum logic [2:0] {RUN, MEM_STALL, LU_STALL, FLUSH, TRAP} state_e;
  localparam logic [31:0] TRAP_VEC_DEF = 32'h0000_0100;
  localparam logic [31:0] PC_INC = 32'd4;
endpackage

// File: rtl/pc_hazard_ctrl_hazard_detect.sv
// hazard_detect: flags a load in EX whose destination feeds the instruction in ID.
module hazard_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       hazard
);
  assign hazard = ex_mem_read && ex_rd != 5'd0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
endmodule

// File: rtl/pc_hazard_ctrl.sv
// pc_hazard_ctrl: PC/pipeline hazard FSM covering memory stalls, load-use, branches and traps.
module pc_hazard_ctrl import pc_hazard_ctrl_pkg::*; #(
  parameter logic [31:0] TRAP_VEC = TRAP_VEC_DEF,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      if_pc,
  input  logic [31:0]      ex_pc,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_target,
  input  logic             mem_busy,
  input  logic             irq_req,
  input  logic             mret_req,
  output logic             stop,
  output logic [31:0]      npc,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             id_ex_bubble,
  output logic             irq_ack,
  output logic [31:0]      epc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_e state_q, state_d, resume_q, resume_d, eff;
  logic [31:0] epc_q;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic irq_ack_q, hazard, take_irq;

  hazard_detect u_hazard_detect (
    .ex_mem_read(ex_mem_read),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .hazard     (hazard)
  );

  // A memory stall is transparent: events are judged as if in the interrupted state.
  always_comb begin
    eff = state_q == MEM_STALL ? resume_q : state_q;
    stop = 1'b0;
    npc = if_pc + PC_INC;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    id_ex_bubble = 1'b0;
    take_irq = 1'b0;
    state_d = state_q;
    resume_d = resume_q;
    if (!rst_n) begin
      state_d = RUN;
    end else if (mem_busy) begin
      stop = 1'b1;
      state_d = MEM_STALL;
      resume_d = eff;
    end else if (eff == RUN && irq_req) begin
      npc = TRAP_VEC;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      take_irq = 1'b1;
      state_d = TRAP;
    end else if (eff == TRAP && mret_req) begin
      npc = epc_q;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d = FLUSH;
    end else if ((eff == RUN || eff == LU_STALL) && ex_branch_taken) begin
      npc = ex_target;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d = FLUSH;
    end else if (eff == RUN && hazard) begin
      stop = 1'b1;
      id_ex_bubble = 1'b1;
      state_d = LU_STALL;
    end else begin
      state_d = eff == TRAP ? TRAP : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      resume_q <= RUN;
      epc_q <= '0;
      irq_ack_q <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      resume_q <= resume_d;
      irq_ack_q <= take_irq;
      if (take_irq) epc_q <= ex_pc;
      if (stop && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
      if (if_id_flush && !(&flush_q)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign irq_ack = irq_ack_q;
  assign epc = epc_q;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// tb_pc_hazard_ctrl: directed and random checks of pc_hazard_ctrl against a behavioural model.
module tb_pc_hazard_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] if_pc, ex_pc, ex_target;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_mem_read, ex_branch_taken, mem_busy, irq_req, mret_req;
  logic stop, if_id_flush, id_ex_flush, id_ex_bubble, irq_ack;
  logic [31:0] npc, epc;
  logic [15:0] stall_cnt, flush_cnt;
  logic stop2, iff2, idf2, bub2, ack2;
  logic [31:0] npc2, epc2;
  logic [2:0] stall2, flush2;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  pc_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .ex_pc(ex_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_target(ex_target), .mem_busy(mem_busy), .irq_req(irq_req), .mret_req(mret_req),
    .stop(stop), .npc(npc), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .id_ex_bubble(id_ex_bubble), .irq_ack(irq_ack), .epc(epc), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  // Narrow-counter instance exposes saturation quickly.
  pc_hazard_ctrl #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .ex_pc(ex_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .ex_target(ex_target), .mem_busy(mem_busy), .irq_req(irq_req), .mret_req(mret_req),
    .stop(stop2), .npc(npc2), .if_id_flush(iff2), .id_ex_flush(idf2),
    .id_ex_bubble(bub2), .irq_ack(ack2), .epc(epc2), .stall_cnt(stall2), .flush_cnt(flush2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode flags (in a trap handler, on a wrong-path cycle, just after a load-use bubble).
  bit m_trap, m_wrong, m_lu, m_ack, took, haz;
  logic [31:0] m_epc, e_npc;
  bit e_stop, e_flush, e_bub;
  int m_stalls, m_flushes;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_trap = 0; m_wrong = 0; m_lu = 0; m_ack = 0; m_epc = 0; m_stalls = 0; m_flushes = 0;
    end
    chk("irq_ack", {31'd0, irq_ack}, {31'd0, m_ack});
    chk("epc", epc, m_epc);
    chk("stall_cnt", {16'd0, stall_cnt}, m_stalls > 65535 ? 65535 : m_stalls);
    chk("flush_cnt", {16'd0, flush_cnt}, m_flushes > 65535 ? 65535 : m_flushes);
    chk("stall_cnt_w3", {29'd0, stall2}, m_stalls > 7 ? 7 : m_stalls);
    e_stop = 0; e_flush = 0; e_bub = 0; took = 0; e_npc = if_pc + 32'd4;
    haz = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (!rst_n) begin
    end else if (mem_busy) begin
      e_stop = 1;
    end else if (m_wrong) begin
      m_wrong = 0;
    end else if (m_trap) begin
      if (mret_req) begin
        e_npc = m_epc; e_flush = 1; m_trap = 0; m_wrong = 1;
      end
    end else if (irq_req && !m_lu) begin
      e_npc = 32'h100; e_flush = 1; took = 1; m_trap = 1;
    end else if (ex_branch_taken) begin
      e_npc = ex_target; e_flush = 1; m_wrong = 1; m_lu = 0;
    end else if (haz && !m_lu) begin
      e_stop = 1; e_bub = 1; m_lu = 1;
    end else begin
      m_lu = 0;
    end
    chk("stop", {31'd0, stop}, {31'd0, e_stop});
    if (!e_stop) chk("npc", npc, e_npc);
    chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, e_flush});
    chk("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, e_flush});
    chk("id_ex_bubble", {31'd0, id_ex_bubble}, {31'd0, e_bub});
    if (rst_n) begin
      m_ack = took;
      if (took) m_epc = ex_pc;
      if (e_stop) m_stalls++;
      if (e_flush) m_flushes++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_mem_read = 0; ex_branch_taken = 0; mem_busy = 0; irq_req = 0; mret_req = 0;
    ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
  endtask

  initial begin
    idle();
    if_pc = 32'h1000; ex_pc = 0; ex_target = 0;
    cyc();
    mem_busy = 1;
    #3;
    chk("reset_stop", {31'd0, stop}, 32'd0);
    chk("reset_npc", npc, 32'h1004);
    chk("reset_epc", epc, 32'd0);
    chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    cyc(); rst_n = 1; mem_busy = 0;
    cyc(); if_pc = 32'hFFFF_FFFC; #3;
    chk("npc_wrap", npc, 32'd0);
    cyc(); if_pc = 32'h200; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; #3;
    chk("lu_stop", {31'd0, stop}, 32'd1);
    chk("lu_bubble", {31'd0, id_ex_bubble}, 32'd1);
    cyc(); #3;
    chk("lu_once_stop", {31'd0, stop}, 32'd0);
    cyc(); ex_rd = 0; id_rs1 = 0; #3;
    chk("lu_x0_stop", {31'd0, stop}, 32'd0);
    cyc(); ex_mem_read = 0; ex_branch_taken = 1; ex_target = 32'h40; #3;
    chk("br_npc", npc, 32'h40);
    chk("br_if_id_flush", {31'd0, if_id_flush}, 32'd1);
    chk("br_id_ex_flush", {31'd0, id_ex_flush}, 32'd1);
    cyc(); ex_target = 32'h80; #3;
    chk("br_wrong_path_npc", npc, 32'h204);
    chk("br_wrong_path_flush", {31'd0, if_id_flush}, 32'd0);
    cyc(); ex_branch_taken = 0; #3;
    chk("br_flush_cnt", {16'd0, flush_cnt}, 32'd1);
    cyc(); irq_req = 1; ex_pc = 32'h1C; #3;
    chk("irq_npc", npc, 32'h100);
    chk("irq_flush", {31'd0, id_ex_flush}, 32'd1);
    cyc(); ex_pc = 32'h50; #3;
    chk("irq_ack_pulse", {31'd0, irq_ack}, 32'd1);
    chk("irq_epc", epc, 32'h1C);
    chk("irq_masked_npc", npc, 32'h204);
    cyc(); #3;
    chk("irq_ack_end", {31'd0, irq_ack}, 32'd0);
    cyc(); irq_req = 0; mret_req = 1; #3;
    chk("mret_npc", npc, 32'h1C);
    cyc(); mret_req = 0;
    cyc(); irq_req = 1; ex_pc = 32'h2C;
    cyc(); irq_req = 0;
    cyc(); rst_n = 0; #3;
    chk("trap_reset_epc", epc, 32'd0);
    cyc(); rst_n = 1; irq_req = 1; ex_pc = 32'h3C; #3;
    chk("irq_after_reset_npc", npc, 32'h100);
    cyc(); irq_req = 0; #3;
    chk("irq_after_reset_epc", epc, 32'h3C);
    cyc(); rst_n = 0;
    cyc(); rst_n = 1;
    cyc(); mem_busy = 1; ex_branch_taken = 1; ex_target = 32'h300;
    for (int k = 0; k < 3; k++) begin
      #3;
      chk("mem_stall_stop", {31'd0, stop}, 32'd1);
      chk("mem_stall_flush", {31'd0, if_id_flush}, 32'd0);
      cyc();
    end
    mem_busy = 0; #3;
    chk("mem_exit_npc", npc, 32'h300);
    cyc(); ex_branch_taken = 0; #3;
    chk("mem_stall_cnt", {16'd0, stall_cnt}, 32'd3);
    for (int i = 0; i < 2000; i++) begin
      cyc();
      rst_n = (i > 1800) || ($urandom_range(0, 199) != 0);
      mem_busy = ($urandom_range(0, 4) == 0);
      irq_req = ($urandom_range(0, 7) == 0);
      mret_req = ($urandom_range(0, 5) == 0);
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      ex_mem_read = $urandom_range(0, 1) == 1;
      ex_rd = 5'($urandom_range(0, 3));
      id_rs1 = 5'($urandom_range(0, 3));
      id_rs2 = 5'($urandom_range(0, 3));
      if_pc = $urandom & 32'hFFFF_FFFC;
      ex_pc = $urandom & 32'hFFFF_FFFC;
      ex_target = $urandom & 32'hFFFF_FFFC;
    end
    cyc(); idle(); rst_n = 1; mem_busy = 1;
    repeat (8) cyc();
    mem_busy = 0; #3;
    chk("stall_cnt_saturated", {29'd0, stall2}, 32'd7);
    cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
